handle_guess_master: RTL and testbench
======================================

// Module: handle_guess_master
// PURPOSE
//  Master-board guess handler: the transmitting end of the interboard SEL_NUM exchange.
//  - On the local P1 turn: validates the entered number, marks it on the local board,
//    and sends SEL_NUM with that number to the slave through a valid/ready TX port.
//  - On the P2 turn: marks the number the slave reports.
//  - Keeps a registered count of completed bingo lines for the game controller.
// PARAMETERS
//  CELLS   25  board cells; circle width
//  POS_W   5   width of one num_to_pos entry and of a number
//  MSG_W   3   interboard message-type width (encodings from message_macro.v)
// PORTS
//  clk                  in   1        system clock
//  rst_n                in   1        asynchronous active-low reset
//  interboard_rst       in   1        synchronous reset from the link; same effect as rst_n
//  interboard_en        in   1        received-message strobe, 1 cycle
//  interboard_msg_type  in   MSG_W    received type (`SEL_NUM, `STATE_WIN, ...)
//  interboard_number    in   POS_W    received number, 1..25
//  cur_game_state       in   4        game FSM state (`GAME_P1_GUESS, `GAME_WAIT_P2_GUESS)
//  start_guess          in   1        arm one guess round
//  clear_guess          in   1        clear all circles
//  cur_number_BCD       in   8        local entry; [7:4] tens, [3:0] ones
//  enter_pulse          in   1        local confirm, 1 cycle
//  num_to_pos           in   POS_W*CELLS  position of number n at [n*5-1 -: 5]
//  tx_ready             in   1        interboard sender accepts
//  tx_valid             out  1        outgoing message valid
//  tx_msg_type          out  MSG_W    always `SEL_NUM while tx_valid
//  tx_number            out  POS_W    guessed number
//  guess_done           out  1        1-cycle pulse: round complete
//  circle               out  CELLS    marked cells
//  line_count           out  4        completed lines, 0..12
// BEHAVIOUR
//  Reset: rst_n low (async) or interboard_rst high (sync) clears everything.
//  - State -> IDLE; circle, line_count, tx_number -> 0.
//  - tx_valid, guess_done -> 0; tx_msg_type -> 0.
//  Local number is valid iff:
//  - Both BCD digits are <= 9.
//  - n = 10*tens+ones lies in 1..25.
//  - pos = num_to_pos[n*5-1 -: 5] is < 25.
//  - circle[pos] == 0.
//  Remote number is valid iff it lies in 1..25 and its pos is < 25.
//  - An invalid remote number completes the round without marking.
//  FSM, encoded IDLE=0, WAIT=1, SEND=2, FIN=3:
//  - IDLE: start_guess -> WAIT.
//  - WAIT, first match wins:
//    (a) interboard_en & `STATE_WIN -> IDLE; nothing is marked.
//    (b) `GAME_P1_GUESS & enter_pulse & local number valid:
//        set circle[pos]; latch tx_number=n; -> SEND.
//        Invalid or duplicate entry: ignored, stay in WAIT.
//    (c) `GAME_WAIT_P2_GUESS & interboard_en & `SEL_NUM:
//        set circle[pos] if valid; -> FIN.
//  - SEND: tx_valid=1; tx_msg_type/tx_number held stable until handshake.
//    - tx_valid & tx_ready -> FIN; tx_valid deasserts the next cycle.
//    - interboard_en & `STATE_WIN -> IDLE with tx_valid dropped. This is the only
//      case where valid falls without ready; the circle mark is kept.
//  - FIN: guess_done=1 for exactly one cycle -> IDLE.
//  - start_guess outside IDLE and enter_pulse outside WAIT are ignored.
//  Latency: the mark is visible the cycle after enter_pulse.
//  - tx_valid rises in that same cycle.
//  - guess_done is one cycle after the handshake cycle.
//  clear_guess: circle -> 0 next cycle.
//  - Overrides any mark in the same cycle.
//  - FSM and TX state unaffected.
//  line_count: registered; counts 5 rows, 5 columns and 2 diagonals fully set.
//  - Reflects circle with one cycle of lag.
// TESTING
//  1. Reset: after rst_n low, all outputs 0. Release, pulse start_guess -> state WAIT.
//  2. P1 guess: BCD 8'h07, num_to_pos maps 7->pos 3, enter_pulse.
//     -> circle[3]=1; tx_valid=1, tx_number=7.
//     Hold tx_ready=0 for 4 cycles -> outputs stable.
//     tx_ready=1 -> guess_done pulses 2 cycles later.
//  3. Invalid entry: BCD 8'h26, then 8'h0A, then a number already circled.
//     -> no mark, no tx_valid, stays WAIT; a following valid entry proceeds.
//  4. P2 remote: `GAME_WAIT_P2_GUESS, interboard_en, `SEL_NUM, number 25 -> pos 24.
//     -> circle[24]=1; guess_done 1 cycle later; tx_valid never asserts.
//  5. Abort: in SEND with tx_ready=0, interboard `STATE_WIN.
//     -> tx_valid=0 next cycle, IDLE, no guess_done.
//  6. Lines: mark row 0 and the main diagonal -> line_count=2 one cycle after the
//     last mark. clear_guess same cycle as a mark -> circle=0, then line_count=0.

Source files
------------

// File: rtl/handle_guess_master.sv
// Master-side guess handler: validates and sends the local P1 guess over a
// valid/ready TX port, marks the slave's reported P2 guess, and keeps a
// registered count of completed bingo lines.
module handle_guess_master #(
  parameter int unsigned CELLS = 25,
  parameter int unsigned POS_W = 5,
  parameter int unsigned MSG_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     interboard_rst,
  input  logic                     interboard_en,
  input  logic [MSG_W-1:0]         interboard_msg_type,
  input  logic [POS_W-1:0]         interboard_number,
  input  logic [3:0]               cur_game_state,
  input  logic                     start_guess,
  input  logic                     clear_guess,
  input  logic [7:0]               cur_number_BCD,
  input  logic                     enter_pulse,
  input  logic [POS_W*CELLS-1:0]   num_to_pos,
  input  logic                     tx_ready,
  output logic                     tx_valid,
  output logic [MSG_W-1:0]         tx_msg_type,
  output logic [POS_W-1:0]         tx_number,
  output logic                     guess_done,
  output logic [CELLS-1:0]         circle,
  output logic [3:0]               line_count
);

  // Board is square; line counting assumes CELLS == SIDE*SIDE.
  localparam int unsigned SIDE = 5;

  // Interboard message and game-state encodings shared with the link/game FSM.
  localparam logic [MSG_W-1:0] MSG_SEL_NUM        = MSG_W'(1);
  localparam logic [MSG_W-1:0] MSG_STATE_WIN      = MSG_W'(3);
  localparam logic [3:0]       GAME_P1_GUESS      = 4'd3;
  localparam logic [3:0]       GAME_WAIT_P2_GUESS = 4'd4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [CELLS-1:0] mark_c;
  logic             latch_c;
  logic             win_c;

  logic [3:0]       tens;
  logic [3:0]       ones;
  logic [6:0]       loc_n7;
  logic [POS_W-1:0] loc_n;
  logic [POS_W-1:0] loc_pos;
  logic [CELLS-1:0] loc_mask;
  logic             loc_valid;
  logic [POS_W-1:0] rem_pos;
  logic [CELLS-1:0] rem_mask;
  logic             rem_valid;

  logic [3:0]       lines_c;
  logic             row_f;
  logic             col_f;
  logic             dia_f;
  logic             ant_f;

  // Table lookup; numbers outside 1..CELLS map to an all-ones (invalid) position.
  function automatic logic [POS_W-1:0] pos_of(input logic [POS_W-1:0]       num,
                                               input logic [POS_W*CELLS-1:0] tbl);
    logic [POS_W-1:0] p;
    p = '1;
    for (int i = 1; i <= int'(CELLS); i++) begin
      if (num == POS_W'(i)) p = tbl[i*POS_W-1 -: POS_W];
    end
    return p;
  endfunction

  // Decode and validate the local BCD entry and the remote number.
  always_comb begin
    tens      = cur_number_BCD[7:4];
    ones      = cur_number_BCD[3:0];
    loc_n7    = 7'(tens) * 7'd10 + 7'(ones);
    loc_n     = POS_W'(loc_n7);
    loc_pos   = pos_of(loc_n, num_to_pos);
    loc_mask  = CELLS'(1) << loc_pos;
    loc_valid = (tens <= 4'd9) && (ones <= 4'd9) &&
                (loc_n7 != 7'd0) && (loc_n7 <= 7'(CELLS)) &&
                (loc_pos < POS_W'(CELLS)) && ((circle & loc_mask) == '0);
    rem_pos   = pos_of(interboard_number, num_to_pos);
    rem_mask  = CELLS'(1) << rem_pos;
    rem_valid = rem_pos < POS_W'(CELLS);
    win_c     = interboard_en && (interboard_msg_type == MSG_STATE_WIN);
  end

  // Count fully marked rows, columns and both diagonals.
  always_comb begin
    lines_c = 4'd0;
    row_f   = 1'b0;
    col_f   = 1'b0;
    dia_f   = 1'b1;
    ant_f   = 1'b1;
    for (int r = 0; r < int'(SIDE); r++) begin
      row_f = 1'b1;
      col_f = 1'b1;
      for (int c = 0; c < int'(SIDE); c++) begin
        row_f = row_f & circle[r*SIDE + c];
        col_f = col_f & circle[c*SIDE + r];
      end
      if (row_f) lines_c = lines_c + 4'd1;
      if (col_f) lines_c = lines_c + 4'd1;
      dia_f = dia_f & circle[r*SIDE + r];
      ant_f = ant_f & circle[r*SIDE + (SIDE-1-r)];
    end
    if (dia_f) lines_c = lines_c + 4'd1;
    if (ant_f) lines_c = lines_c + 4'd1;
  end

  // Next-state and mark/latch decisions for one guess round.
  always_comb begin
    state_nx = state;
    mark_c   = '0;
    latch_c  = 1'b0;
    case (state)
      S_IDLE: if (start_guess) state_nx = S_WAIT;
      S_WAIT: begin
        if (win_c) begin
          state_nx = S_IDLE;
        end else if ((cur_game_state == GAME_P1_GUESS) && enter_pulse && loc_valid) begin
          mark_c   = loc_mask;
          latch_c  = 1'b1;
          state_nx = S_SEND;
        end else if ((cur_game_state == GAME_WAIT_P2_GUESS) && interboard_en &&
                     (interboard_msg_type == MSG_SEL_NUM)) begin
          if (rem_valid) mark_c = rem_mask;
          state_nx = S_FIN;
        end
      end
      S_SEND: begin
        if (tx_valid && tx_ready) state_nx = S_FIN;
        else if (win_c)           state_nx = S_IDLE;
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State, board and TX registers; link reset behaves like rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      circle      <= '0;
      line_count  <= 4'd0;
      tx_valid    <= 1'b0;
      tx_msg_type <= '0;
      tx_number   <= '0;
      guess_done  <= 1'b0;
    end else if (interboard_rst) begin
      state       <= S_IDLE;
      circle      <= '0;
      line_count  <= 4'd0;
      tx_valid    <= 1'b0;
      tx_msg_type <= '0;
      tx_number   <= '0;
      guess_done  <= 1'b0;
    end else begin
      state       <= state_nx;
      circle      <= clear_guess ? '0 : (circle | mark_c);
      line_count  <= lines_c;
      tx_valid    <= (state_nx == S_SEND);
      tx_msg_type <= (state_nx == S_SEND) ? MSG_SEL_NUM : '0;
      if (latch_c) tx_number <= loc_n;
      guess_done  <= (state == S_FIN);
    end
  end

endmodule

// File: tb/tb_handle_guess_master.sv
// Bench for handle_guess_master: directed scenarios followed by randomized
// traffic, all checked against a round-level behavioural model.
`timescale 1ns/1ps
module tb_handle_guess_master;

  localparam int CELLS = 25;
  localparam int POS_W = 5;
  localparam int MSG_W = 3;
  localparam logic [2:0] MSG_SEL = 3'd1;
  localparam logic [2:0] MSG_WIN = 3'd3;
  localparam logic [3:0] G_P1    = 4'd3;
  localparam logic [3:0] G_P2    = 4'd4;

  // Round phases of the reference model.
  localparam int PH_IDLE = 0, PH_ARMED = 1, PH_SENDING = 2, PH_DONE = 3;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   interboard_rst = 1'b0;
  logic                   interboard_en = 1'b0;
  logic [MSG_W-1:0]       interboard_msg_type = '0;
  logic [POS_W-1:0]       interboard_number = '0;
  logic [3:0]             cur_game_state = '0;
  logic                   start_guess = 1'b0;
  logic                   clear_guess = 1'b0;
  logic [7:0]             cur_number_BCD = '0;
  logic                   enter_pulse = 1'b0;
  logic [POS_W*CELLS-1:0] num_to_pos = '0;
  logic                   tx_ready = 1'b0;
  logic                   tx_valid;
  logic [MSG_W-1:0]       tx_msg_type;
  logic [POS_W-1:0]       tx_number;
  logic                   guess_done;
  logic [CELLS-1:0]       circle;
  logic [3:0]             line_count;

  handle_guess_master dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .interboard_rst      (interboard_rst),
    .interboard_en       (interboard_en),
    .interboard_msg_type (interboard_msg_type),
    .interboard_number   (interboard_number),
    .cur_game_state      (cur_game_state),
    .start_guess         (start_guess),
    .clear_guess         (clear_guess),
    .cur_number_BCD      (cur_number_BCD),
    .enter_pulse         (enter_pulse),
    .num_to_pos          (num_to_pos),
    .tx_ready            (tx_ready),
    .tx_valid            (tx_valid),
    .tx_msg_type         (tx_msg_type),
    .tx_number           (tx_number),
    .guess_done          (guess_done),
    .circle              (circle),
    .line_count          (line_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int   ph;
  bit   m [CELLS];
  int   map [1:CELLS];
  int   m_txn;
  bit   m_tv;
  bit   m_gd;
  int   m_lines;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = PH_IDLE;
    for (int i = 0; i < CELLS; i++) m[i] = 1'b0;
    m_txn = 0; m_tv = 1'b0; m_gd = 1'b0; m_lines = 0;
  endtask

  function automatic int lines_of();
    int cnt; bit fr, fc, fd, fa;
    cnt = 0; fd = 1'b1; fa = 1'b1;
    for (int r = 0; r < 5; r++) begin
      fr = 1'b1; fc = 1'b1;
      for (int c = 0; c < 5; c++) begin
        fr &= m[r*5+c];
        fc &= m[c*5+r];
      end
      cnt += int'(fr) + int'(fc);
      fd &= m[r*6];
      fa &= m[r*4+4];
    end
    return cnt + int'(fd) + int'(fa);
  endfunction

  task automatic load_map();
    for (int n = 1; n <= CELLS; n++) num_to_pos[n*5-1 -: 5] = 5'(map[n]);
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    int nph, mk, tens, ones, n, lpos, rpos;
    bit win;
    if (interboard_rst) begin model_reset(); return; end
    m_gd    = (ph == PH_DONE);
    m_lines = lines_of();
    nph = ph; mk = -1;
    win  = interboard_en && (interboard_msg_type == MSG_WIN);
    tens = int'(cur_number_BCD[7:4]);
    ones = int'(cur_number_BCD[3:0]);
    n    = tens*10 + ones;
    lpos = -1;
    if (tens <= 9 && ones <= 9 && n >= 1 && n <= CELLS)
      if (map[n] < CELLS) if (!m[map[n]]) lpos = map[n];
    rpos = -1;
    if (int'(interboard_number) >= 1 && int'(interboard_number) <= CELLS)
      if (map[int'(interboard_number)] < CELLS) rpos = map[int'(interboard_number)];
    case (ph)
      PH_IDLE: if (start_guess) nph = PH_ARMED;
      PH_ARMED: begin
        if (win) nph = PH_IDLE;
        else if (cur_game_state == G_P1 && enter_pulse && lpos >= 0) begin
          mk = lpos; m_txn = n; nph = PH_SENDING;
        end else if (cur_game_state == G_P2 && interboard_en && interboard_msg_type == MSG_SEL) begin
          mk = rpos; nph = PH_DONE;
        end
      end
      PH_SENDING: begin
        if (tx_ready) nph = PH_DONE;
        else if (win) nph = PH_IDLE;
      end
      default: nph = PH_IDLE;
    endcase
    if (clear_guess) for (int i = 0; i < CELLS; i++) m[i] = 1'b0;
    else if (mk >= 0) m[mk] = 1'b1;
    ph   = nph;
    m_tv = (ph == PH_SENDING);
  endtask

  task automatic check_all();
    logic [CELLS-1:0] ec;
    for (int i = 0; i < CELLS; i++) ec[i] = m[i];
    check_eq("tx_valid",    32'(tx_valid),    32'(m_tv));
    check_eq("tx_msg_type", 32'(tx_msg_type), m_tv ? 32'(MSG_SEL) : 32'd0);
    check_eq("tx_number",   32'(tx_number),   32'(m_txn));
    check_eq("guess_done",  32'(guess_done),  32'(m_gd));
    check_eq("circle",      32'(circle),      32'(ec));
    check_eq("line_count",  32'(line_count),  32'(m_lines));
  endtask

  // One clock: edge, model, check, then back to the falling edge with pulses cleared.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    @(negedge clk);
    start_guess = 1'b0; enter_pulse = 1'b0; interboard_en = 1'b0;
    clear_guess = 1'b0; interboard_rst = 1'b0;
  endtask

  task automatic remote_mark(input int n);
    start_guess = 1'b1; cyc();
    cur_game_state = G_P2; interboard_en = 1'b1;
    interboard_msg_type = MSG_SEL; interboard_number = 5'(n); cyc();
    cyc();
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  initial begin
    // Identity map except 7->3 and 4->6.
    for (int n = 1; n <= CELLS; n++) map[n] = n - 1;
    map[7] = 3; map[4] = 6;
    load_map();
    model_reset();

    #3;
    check_all();
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_circle",   32'(circle),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // P1 guess with held ready.
    start_guess = 1'b1; cyc();
    cur_game_state = G_P1; cur_number_BCD = 8'h07; enter_pulse = 1'b1; cyc();
    check_eq("p1_circle3",  32'(circle[3]), 32'd1);
    check_eq("p1_tx_valid", 32'(tx_valid),  32'd1);
    check_eq("p1_tx_num",   32'(tx_number), 32'd7);
    repeat (4) cyc();
    tx_ready = 1'b1; cyc();
    check_eq("p1_done_early", 32'(guess_done), 32'd0);
    tx_ready = 1'b0; cyc();
    check_eq("p1_done", 32'(guess_done), 32'd1);

    // Invalid entries, then a valid one.
    start_guess = 1'b1; cyc();
    cur_number_BCD = 8'h26; enter_pulse = 1'b1; cyc();
    cur_number_BCD = 8'h0A; enter_pulse = 1'b1; cyc();
    cur_number_BCD = 8'h07; enter_pulse = 1'b1; cyc();
    check_eq("dup_no_tx", 32'(tx_valid), 32'd0);
    cur_number_BCD = 8'h08; enter_pulse = 1'b1; cyc();
    check_eq("valid_tx", 32'(tx_valid), 32'd1);
    tx_ready = 1'b1; cyc();
    tx_ready = 1'b0; cyc();

    // P2 remote number 25.
    start_guess = 1'b1; cyc();
    cur_game_state = G_P2; interboard_en = 1'b1;
    interboard_msg_type = MSG_SEL; interboard_number = 5'd25; cyc();
    check_eq("p2_circle24", 32'(circle[24]), 32'd1);
    check_eq("p2_no_tx",    32'(tx_valid),   32'd0);
    cyc();
    check_eq("p2_done", 32'(guess_done), 32'd1);

    // Abort while sending.
    start_guess = 1'b1; cyc();
    cur_game_state = G_P1; cur_number_BCD = 8'h09; enter_pulse = 1'b1; cyc();
    interboard_en = 1'b1; interboard_msg_type = MSG_WIN; cyc();
    check_eq("abort_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("abort_keep",     32'(circle[8]), 32'd1);
    cyc();
    check_eq("abort_no_done", 32'(guess_done), 32'd0);

    // Lines: row 0 and main diagonal, then clear racing a mark.
    clear_guess = 1'b1; cyc();
    remote_mark(1); remote_mark(2); remote_mark(3); remote_mark(7); remote_mark(5);
    remote_mark(4); remote_mark(13); remote_mark(19); remote_mark(25);
    check_eq("lines_two", 32'(line_count), 32'd2);
    start_guess = 1'b1; cyc();
    cur_game_state = G_P2; interboard_en = 1'b1; interboard_msg_type = MSG_SEL;
    interboard_number = 5'd10; clear_guess = 1'b1; cyc();
    check_eq("clear_wins", 32'(circle), 32'd0);
    cyc();
    check_eq("lines_zero", 32'(line_count), 32'd0);

    // Randomized traffic with occasional map reshuffles.
    for (int it = 0; it < 4000; it++) begin
      if (it % 500 == 0) begin
        for (int i = CELLS; i >= 2; i--) begin
          int j, t;
          j = int'($urandom_range(1, i));
          t = map[i]; map[i] = map[j]; map[j] = t;
        end
        if (it % 1000 == 0) map[int'($urandom_range(1, CELLS))] = int'($urandom_range(25, 31));
        load_map();
      end
      if (it == 2000) begin
        rst_n = 1'b0; #1;
        model_reset();
        check_all();
        #1 rst_n = 1'b1;
      end
      begin
        int r;
        r = int'($urandom_range(0, 9));
        cur_game_state = (r < 5) ? G_P1 : (r < 8) ? G_P2 : 4'($urandom);
        start_guess    = ($urandom_range(0, 3) == 0);
        enter_pulse    = ($urandom_range(0, 2) == 0);
        cur_number_BCD = ($urandom_range(0, 4) != 0) ? to_bcd(int'($urandom_range(1, 25)))
                                                     : 8'($urandom);
        interboard_en  = ($urandom_range(0, 3) == 0);
        r = int'($urandom_range(0, 9));
        interboard_msg_type = (r < 5) ? MSG_SEL : (r < 7) ? MSG_WIN : 3'($urandom);
        interboard_number = 5'($urandom);
        tx_ready       = ($urandom_range(0, 2) == 0);
        clear_guess    = ($urandom_range(0, 39) == 0);
        interboard_rst = ($urandom_range(0, 149) == 0);
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
